// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: FSM states,
// access-size encodings, byte-lane mask and alignment check.
package dmem_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_WRITE,
        S_RESP
    } state_t;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] m;
        case (size)
            SIZE_B:  m = 4'b0001 << off;
            SIZE_H:  m = 4'b0011 << off;
            SIZE_W:  m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Illegal size (11, or unsigned word 110) counts as a failed access too.
    function automatic logic misaligned(input logic [2:0] size, input logic [1:0] off);
        logic bad;
        case (size[1:0])
            SIZE_B:  bad = 1'b0;
            SIZE_H:  bad = off[0];
            SIZE_W:  bad = size[2] | (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane_merge.sv
// Byte-lane datapath: extracts and extends load data from a RAM word, and
// merges sub-word store data into a RAM word for read-modify-write.
module dmem_lane_merge
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_word,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [2:0]        i_size,
    input  logic [1:0]        i_off,
    output logic [DATA_W-1:0] o_load,
    output logic [DATA_W-1:0] o_merge
);

    logic [DATA_W-1:0] w_shifted;
    logic [DATA_W-1:0] w_wshift;
    logic [3:0]        w_mask;
    logic              w_sext;

    always_comb begin
        w_shifted = i_word >> {i_off, 3'b000};
        w_wshift  = i_wdata << {i_off, 3'b000};
        w_mask    = lane_mask(i_size[1:0], i_off);
        w_sext    = ~i_size[2];
        case (i_size[1:0])
            SIZE_B:  o_load = {{(DATA_W-8){w_sext & w_shifted[7]}}, w_shifted[7:0]};
            SIZE_H:  o_load = {{(DATA_W-16){w_sext & w_shifted[15]}}, w_shifted[15:0]};
            default: o_load = w_shifted;
        endcase
        o_merge = i_word;
        for (int unsigned i = 0; i < 4; i++) begin
            if (w_mask[i]) o_merge[8*i +: 8] = w_wshift[8*i +: 8];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: byte/half/word loads and stores onto a word-wide RAM
// without byte enables, using read-modify-write for sub-word stores.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 12,
    parameter int RAM_ADD = 10
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic [ADDR_W-1:0]  REQ_ADDR,
    input  logic [DATA_W-1:0]  REQ_WDATA,
    input  logic               REQ_READ,
    input  logic               REQ_WRITE,
    input  logic [2:0]         REQ_SIZE,
    output logic               ACK,
    output logic [DATA_W-1:0]  RDATA,
    output logic               ERR,
    output logic [RAM_ADD-1:0] RAM_ADDRESS,
    output logic [DATA_W-1:0]  RAM_DATAIN,
    output logic               RAM_WR,
    input  logic [DATA_W-1:0]  RAM_DATAOUT
);

    state_t            r_state;
    logic [1:0]        r_off;
    logic [DATA_W-1:0] r_wdata;
    logic [2:0]        r_size;
    logic              r_is_wr;
    logic [DATA_W-1:0] w_load;
    logic [DATA_W-1:0] w_merge;

    dmem_lane_merge #(.DATA_W(DATA_W)) u_lane (
        .i_word  (RAM_DATAOUT),
        .i_wdata (r_wdata),
        .i_size  (r_size),
        .i_off   (r_off),
        .o_load  (w_load),
        .o_merge (w_merge)
    );

    // Outputs are set on the transition into the state that owns them, so
    // each becomes visible exactly during that state.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= S_IDLE;
            r_off       <= '0;
            r_wdata     <= '0;
            r_size      <= '0;
            r_is_wr     <= 1'b0;
            ACK         <= 1'b0;
            ERR         <= 1'b0;
            RDATA       <= '0;
            RAM_WR      <= 1'b0;
            RAM_ADDRESS <= '0;
            RAM_DATAIN  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (REQ_WRITE || REQ_READ) begin
                        r_off   <= REQ_ADDR[1:0];
                        r_wdata <= REQ_WDATA;
                        r_size  <= REQ_SIZE;
                        r_is_wr <= REQ_WRITE;
                        if (misaligned(REQ_SIZE, REQ_ADDR[1:0])) begin
                            ACK     <= 1'b1;
                            ERR     <= 1'b1;
                            r_state <= S_RESP;
                        end else begin
                            RAM_ADDRESS <= REQ_ADDR[ADDR_W-1:2];
                            if (REQ_WRITE && REQ_SIZE[1:0] == SIZE_W) begin
                                RAM_WR     <= 1'b1;
                                RAM_DATAIN <= REQ_WDATA;
                                r_state    <= S_WRITE;
                            end else begin
                                r_state <= S_ISSUE;
                            end
                        end
                    end
                end
                S_ISSUE: r_state <= S_CAPTURE;
                S_CAPTURE: begin
                    if (r_is_wr) begin
                        RAM_WR     <= 1'b1;
                        RAM_DATAIN <= w_merge;
                        r_state    <= S_WRITE;
                    end else begin
                        RDATA   <= w_load;
                        ACK     <= 1'b1;
                        r_state <= S_RESP;
                    end
                end
                S_WRITE: begin
                    RAM_WR  <= 1'b0;
                    ACK     <= 1'b1;
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    ACK     <= 1'b0;
                    ERR     <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: behavioural RAM, scoreboard of
// expected responses, latency / RAM-write monitoring and mid-operation reset.
module tb_dmem_responder;

    logic        CLK;
    logic        RESET_N;
    logic [11:0] REQ_ADDR;
    logic [31:0] REQ_WDATA;
    logic        REQ_READ;
    logic        REQ_WRITE;
    logic [2:0]  REQ_SIZE;
    logic        ACK;
    logic [31:0] RDATA;
    logic        ERR;
    logic [9:0]  RAM_ADDRESS;
    logic [31:0] RAM_DATAIN;
    logic        RAM_WR;
    logic [31:0] RAM_DATAOUT;

    logic [31:0] mem [1024];

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          lat;
        logic [31:0] rdata;
        logic        err;
        bit          chk_rdata;
        int          wr_pulses;
        int          wr_cycle;
    } exp_t;

    typedef struct {
        logic [11:0] a;
        logic [31:0] wd;
        logic        rd;
        logic        wr;
        logic [2:0]  sz;
        exp_t        e;
    } req_t;

    exp_t sb[$];

    dmem_responder #(.DATA_W(32), .ADDR_W(12), .RAM_ADD(10)) dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .REQ_ADDR    (REQ_ADDR),
        .REQ_WDATA   (REQ_WDATA),
        .REQ_READ    (REQ_READ),
        .REQ_WRITE   (REQ_WRITE),
        .REQ_SIZE    (REQ_SIZE),
        .ACK         (ACK),
        .RDATA       (RDATA),
        .ERR         (ERR),
        .RAM_ADDRESS (RAM_ADDRESS),
        .RAM_DATAIN  (RAM_DATAIN),
        .RAM_WR      (RAM_WR),
        .RAM_DATAOUT (RAM_DATAOUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (RAM_WR) mem[RAM_ADDRESS] <= RAM_DATAIN;
        RAM_DATAOUT <= mem[RAM_ADDRESS];
    end

    // Drives one request at a negedge (cycle C0), holds it until ACK, and
    // reports ACK latency, response data and RAM write activity.
    task automatic issue(input req_t r, output int lat, output logic [31:0] rdo,
                         output logic ero, output int wrp, output int wrc);
        bit done;
        sb.push_back(r.e);
        @(negedge CLK);
        REQ_ADDR  = r.a;
        REQ_WDATA = r.wd;
        REQ_READ  = r.rd;
        REQ_WRITE = r.wr;
        REQ_SIZE  = r.sz;
        lat = -1; rdo = 'x; ero = 1'bx; wrp = 0; wrc = -1; done = 0;
        for (int k = 1; k <= 10 && !done; k++) begin
            @(negedge CLK);
            if (RAM_WR === 1'b1) begin
                wrp++;
                wrc = k;
            end
            if (ACK === 1'b1) begin
                lat  = k;
                rdo  = RDATA;
                ero  = ERR;
                done = 1;
            end
        end
        REQ_READ  = 1'b0;
        REQ_WRITE = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL ack_timeout addr=%h got=no ACK in 10 cycles want=ACK", r.a);
        end
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        REQ_ADDR = '0; REQ_WDATA = '0; REQ_READ = 1'b0; REQ_WRITE = 1'b0; REQ_SIZE = '0;
        repeat (2) @(negedge CLK);
        total++; if (ACK !== 1'b0)        begin bad++; $display("FAIL reset_ack got=%b want=0", ACK); end
        total++; if (ERR !== 1'b0)        begin bad++; $display("FAIL reset_err got=%b want=0", ERR); end
        total++; if (RDATA !== 32'h0)     begin bad++; $display("FAIL reset_rdata got=%h want=0", RDATA); end
        total++; if (RAM_WR !== 1'b0)     begin bad++; $display("FAIL reset_ram_wr got=%b want=0", RAM_WR); end
        total++; if (RAM_ADDRESS !== '0)  begin bad++; $display("FAIL reset_ram_addr got=%h want=0", RAM_ADDRESS); end
        total++; if (RAM_DATAIN !== '0)   begin bad++; $display("FAIL reset_ram_din got=%h want=0", RAM_DATAIN); end
        RESET_N = 1'b1;
    endtask

    task automatic test_loads();
        req_t t[5];
        int lat, wrp, wrc; logic [31:0] rdo; logic ero; exp_t ex;
        t[0] = '{12'h015, 32'h0, 1, 0, 3'b000, '{3, 32'hFFFFFFAA, 0, 1, 0, -1}};
        t[1] = '{12'h016, 32'h0, 1, 0, 3'b101, '{3, 32'h00008899, 0, 1, 0, -1}};
        t[2] = '{12'h016, 32'h0, 1, 0, 3'b001, '{3, 32'hFFFF8899, 0, 1, 0, -1}};
        t[3] = '{12'h014, 32'h0, 1, 0, 3'b100, '{3, 32'h000000BB, 0, 1, 0, -1}};
        t[4] = '{12'h017, 32'h0, 1, 0, 3'b000, '{3, 32'hFFFFFF88, 0, 1, 0, -1}};
        foreach (t[i]) begin
            issue(t[i], lat, rdo, ero, wrp, wrc);
            ex = sb.pop_front();
            total++; if (lat !== ex.lat)     begin bad++; $display("FAIL load_lat[%0d] got=%0d want=%0d", i, lat, ex.lat); end
            total++; if (ero !== ex.err)     begin bad++; $display("FAIL load_err[%0d] got=%b want=%b", i, ero, ex.err); end
            total++; if (rdo !== ex.rdata)   begin bad++; $display("FAIL load_rdata[%0d] got=%h want=%h", i, rdo, ex.rdata); end
            total++; if (wrp !== ex.wr_pulses) begin bad++; $display("FAIL load_ram_wr[%0d] got=%0d want=%0d", i, wrp, ex.wr_pulses); end
        end
    endtask

    task automatic test_sub_store();
        req_t t[2];
        logic [31:0] want[2];
        int lat, wrp, wrc; logic [31:0] rdo; logic ero; exp_t ex;
        t[0] = '{12'h016, 32'h0000005A, 0, 1, 3'b000, '{4, 32'h0, 0, 0, 1, 3}};
        t[1] = '{12'h014, 32'h1234CAFE, 0, 1, 3'b001, '{4, 32'h0, 0, 0, 1, 3}};
        want[0] = 32'h885AAABB;
        want[1] = 32'h885ACAFE;
        foreach (t[i]) begin
            issue(t[i], lat, rdo, ero, wrp, wrc);
            ex = sb.pop_front();
            total++; if (lat !== ex.lat)       begin bad++; $display("FAIL sub_lat[%0d] got=%0d want=%0d", i, lat, ex.lat); end
            total++; if (ero !== ex.err)       begin bad++; $display("FAIL sub_err[%0d] got=%b want=%b", i, ero, ex.err); end
            total++; if (wrp !== ex.wr_pulses) begin bad++; $display("FAIL sub_wr_pulses[%0d] got=%0d want=%0d", i, wrp, ex.wr_pulses); end
            total++; if (wrc !== ex.wr_cycle)  begin bad++; $display("FAIL sub_wr_cycle[%0d] got=%0d want=%0d", i, wrc, ex.wr_cycle); end
            total++; if (mem[5] !== want[i])   begin bad++; $display("FAIL sub_ram[%0d] got=%h want=%h", i, mem[5], want[i]); end
        end
    endtask

    task automatic test_word();
        req_t t[3];
        int lat, wrp, wrc; logic [31:0] rdo; logic ero; exp_t ex;
        t[0] = '{12'h020, 32'h12345678, 0, 1, 3'b010, '{2, 32'h0, 0, 0, 1, 1}};
        t[1] = '{12'h020, 32'h0,        1, 0, 3'b010, '{3, 32'h12345678, 0, 1, 0, -1}};
        // read and write together: the store must win
        t[2] = '{12'h030, 32'hA5A5F00F, 1, 1, 3'b010, '{2, 32'h0, 0, 0, 1, 1}};
        foreach (t[i]) begin
            issue(t[i], lat, rdo, ero, wrp, wrc);
            ex = sb.pop_front();
            total++; if (lat !== ex.lat)       begin bad++; $display("FAIL word_lat[%0d] got=%0d want=%0d", i, lat, ex.lat); end
            total++; if (wrp !== ex.wr_pulses) begin bad++; $display("FAIL word_wr_pulses[%0d] got=%0d want=%0d", i, wrp, ex.wr_pulses); end
            if (ex.wr_pulses != 0) begin
                total++; if (wrc !== ex.wr_cycle) begin bad++; $display("FAIL word_wr_cycle[%0d] got=%0d want=%0d", i, wrc, ex.wr_cycle); end
            end
            if (ex.chk_rdata) begin
                total++; if (rdo !== ex.rdata) begin bad++; $display("FAIL word_rdata[%0d] got=%h want=%h", i, rdo, ex.rdata); end
            end
        end
        total++; if (mem[8] !== 32'h12345678)  begin bad++; $display("FAIL word_ram8 got=%h want=12345678", mem[8]); end
        total++; if (mem[12] !== 32'hA5A5F00F) begin bad++; $display("FAIL word_ram12 got=%h want=a5a5f00f", mem[12]); end
    endtask

    task automatic test_errors();
        req_t t[4];
        int lat, wrp, wrc; logic [31:0] rdo; logic ero; exp_t ex;
        t[0] = '{12'h022, 32'h0,        1, 0, 3'b010, '{1, 32'h0, 1, 0, 0, -1}};
        t[1] = '{12'h023, 32'hDEADBEEF, 0, 1, 3'b001, '{1, 32'h0, 1, 0, 0, -1}};
        t[2] = '{12'h020, 32'h0,        1, 0, 3'b110, '{1, 32'h0, 1, 0, 0, -1}};
        t[3] = '{12'h020, 32'hCAFEF00D, 0, 1, 3'b011, '{1, 32'h0, 1, 0, 0, -1}};
        foreach (t[i]) begin
            issue(t[i], lat, rdo, ero, wrp, wrc);
            ex = sb.pop_front();
            total++; if (lat !== ex.lat)       begin bad++; $display("FAIL err_lat[%0d] got=%0d want=%0d", i, lat, ex.lat); end
            total++; if (ero !== ex.err)       begin bad++; $display("FAIL err_flag[%0d] got=%b want=%b", i, ero, ex.err); end
            total++; if (wrp !== ex.wr_pulses) begin bad++; $display("FAIL err_ram_wr[%0d] got=%0d want=%0d", i, wrp, ex.wr_pulses); end
        end
        @(negedge CLK);
        total++; if (ERR !== 1'b0)            begin bad++; $display("FAIL err_clears got=%b want=0", ERR); end
        total++; if (RDATA !== 32'h12345678)  begin bad++; $display("FAIL err_rdata_hold got=%h want=12345678", RDATA); end
        total++; if (mem[8] !== 32'h12345678) begin bad++; $display("FAIL err_ram_unchanged got=%h want=12345678", mem[8]); end
    endtask

    task automatic test_reset_mid();
        req_t r;
        int lat, wrp, wrc; logic [31:0] rdo; logic ero; exp_t ex;
        bit seen;
        mem[9] = 32'h11223344;
        @(negedge CLK);
        REQ_ADDR = 12'h024; REQ_WDATA = 32'h000000C3; REQ_SIZE = 3'b000;
        REQ_WRITE = 1'b1; REQ_READ = 1'b0;
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge CLK);
            if (RAM_WR === 1'b1) seen = 1;
        end
        total++; if (!seen) begin bad++; $display("FAIL midrst_write_seen got=no RAM_WR want=RAM_WR pulse"); end
        RESET_N = 1'b0;
        #1;
        total++; if (RAM_WR !== 1'b0)    begin bad++; $display("FAIL midrst_ram_wr got=%b want=0", RAM_WR); end
        total++; if (RAM_ADDRESS !== '0) begin bad++; $display("FAIL midrst_ram_addr got=%h want=0", RAM_ADDRESS); end
        total++; if (RAM_DATAIN !== '0)  begin bad++; $display("FAIL midrst_ram_din got=%h want=0", RAM_DATAIN); end
        total++; if (RDATA !== 32'h0)    begin bad++; $display("FAIL midrst_rdata got=%h want=0", RDATA); end
        total++; if (ACK !== 1'b0 || ERR !== 1'b0) begin bad++; $display("FAIL midrst_ack_err got=%b%b want=00", ACK, ERR); end
        REQ_WRITE = 1'b0;
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        total++; if (mem[9] !== 32'h11223344) begin bad++; $display("FAIL midrst_ram got=%h want=11223344", mem[9]); end
        r = '{12'h024, 32'h0, 1, 0, 3'b010, '{3, 32'h11223344, 0, 1, 0, -1}};
        issue(r, lat, rdo, ero, wrp, wrc);
        ex = sb.pop_front();
        total++; if (lat !== ex.lat)     begin bad++; $display("FAIL post_rst_lat got=%0d want=%0d", lat, ex.lat); end
        total++; if (rdo !== ex.rdata)   begin bad++; $display("FAIL post_rst_rdata got=%h want=%h", rdo, ex.rdata); end
        total++; if (ero !== ex.err)     begin bad++; $display("FAIL post_rst_err got=%b want=%b", ero, ex.err); end
    endtask

    initial begin
        foreach (mem[i]) mem[i] = 32'h0;
        mem[5] = 32'h8899AABB;
        test_reset();
        test_loads();
        test_sub_store();
        test_word();
        test_errors();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
